// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared state type, vector width and vector helper for msi_irq_ctrl
package msi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } msi_state_t;

    localparam int MSI_VEC_W = 5;

    // Vector number for a source: base plus index, wrapped to the MSI vector field.
    function automatic logic [MSI_VEC_W-1:0] msi_vec(input int unsigned base, input int unsigned idx);
        int unsigned sum;
        sum = base + idx;
        return sum[MSI_VEC_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting one past the last winner
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] grant_idx
);

    int   cand;
    logic found;

    // Walk the ring from last+1, wrapping, and take the first active request.
    always_comb begin
        any       = |req;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/msi_irq_ctrl.sv
// rtl/msi_irq_ctrl.sv - multi-source MSI controller; MSI_HOLDOFF_EN adds a post-grant holdoff
module msi_irq_ctrl
    import msi_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int VEC_BASE       = 0,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_SRC-1:0]     irq_src,
    input  logic                 msi_enabled,
    input  logic                 msi_grant,
    output logic                 msi_request,
    output logic [MSI_VEC_W-1:0] msi_vector_num,
    output logic [N_SRC-1:0]     pending_o,
    output logic [N_SRC-1:0]     overflow_o,
    input  logic [N_SRC-1:0]     overflow_clr
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    if (N_SRC < 1 || N_SRC > 32 || VEC_BASE < 0 || VEC_BASE + N_SRC > 32 || HOLDOFF_CYCLES < 0)
    begin : g_param_check
        $error("msi_irq_ctrl: need 1<=N_SRC<=32, VEC_BASE>=0, VEC_BASE+N_SRC<=32, HOLDOFF_CYCLES>=0");
    end

    msi_state_t           state, state_nxt;
    logic [N_SRC-1:0]     irq_p;
    logic [N_SRC-1:0]     edge_det;
    logic [N_SRC-1:0]     pend_clr;
    logic [IW-1:0]        svc_idx, svc_idx_nxt;
    logic [IW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]        arb_last, arb_idx;
    logic                 arb_any;
    logic                 grant_fire;
    logic                 req_nxt;
    logic [MSI_VEC_W-1:0] vec_nxt;

`ifdef MSI_HOLDOFF_EN
    localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
`endif

    // rr_ptr holds the next starting slot; the arbiter wants the slot before it.
    assign arb_last = (rr_ptr == '0) ? IW'(N_SRC - 1) : rr_ptr - IW'(1);
    assign edge_det = irq_src & ~irq_p;
    assign pend_clr = grant_fire ? (N_SRC'(1) << svc_idx) : '0;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req       (pending_o),
        .last      (arb_last),
        .any       (arb_any),
        .grant_idx (arb_idx)
    );

    // Edge history, pending latches (set beats clear) and sticky overflow flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_p      <= '0;
            pending_o  <= '0;
            overflow_o <= '0;
        end else begin
            irq_p      <= irq_src;
            pending_o  <= (pending_o & ~pend_clr) | edge_det;
            overflow_o <= (overflow_o & ~overflow_clr) | (edge_det & pending_o & ~pend_clr);
        end
    end

    // Request FSM registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            svc_idx        <= '0;
            rr_ptr         <= '0;
            msi_request    <= 1'b0;
            msi_vector_num <= '0;
`ifdef MSI_HOLDOFF_EN
            hold_cnt       <= '0;
`endif
        end else begin
            state          <= state_nxt;
            svc_idx        <= svc_idx_nxt;
            rr_ptr         <= rr_ptr_nxt;
            msi_request    <= req_nxt;
            msi_vector_num <= vec_nxt;
`ifdef MSI_HOLDOFF_EN
            hold_cnt       <= hold_cnt_nxt;
`endif
        end
    end

    // Next-state logic: issue in IDLE, hold in REQ until grant or enable drop.
    always_comb begin
        state_nxt   = state;
        svc_idx_nxt = svc_idx;
        rr_ptr_nxt  = rr_ptr;
        req_nxt     = msi_request;
        vec_nxt     = msi_vector_num;
        grant_fire  = 1'b0;
`ifdef MSI_HOLDOFF_EN
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (msi_enabled && arb_any) begin
                    svc_idx_nxt = arb_idx;
                    vec_nxt     = msi_vec(VEC_BASE, 32'(arb_idx));
                    req_nxt     = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (msi_grant) begin
                    grant_fire = 1'b1;
                    req_nxt    = 1'b0;
                    rr_ptr_nxt = (svc_idx == IW'(N_SRC - 1)) ? '0 : svc_idx + IW'(1);
`ifdef MSI_HOLDOFF_EN
                    hold_cnt_nxt = '0;
                    state_nxt    = HOLDOFF;
`else
                    state_nxt  = IDLE;
`endif
                end else if (!msi_enabled) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
`ifdef MSI_HOLDOFF_EN
            HOLDOFF: begin
                hold_cnt_nxt = hold_cnt + CW'(1);
                if (hold_cnt_nxt >= CW'(HOLDOFF_CYCLES)) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_msi_irq_ctrl.sv
// tb/tb_msi_irq_ctrl.sv - self-checking bench for msi_irq_ctrl (table, corner sequences, random vs model)
module tb_msi_irq_ctrl;

    localparam int N  = 4;
    localparam int HC = 64;
`ifdef MSI_HOLDOFF_EN
    localparam int EXP_GAP = HC + 2;
`else
    localparam int EXP_GAP = 2;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [N-1:0] irq_src;
    logic [N-1:0] overflow_clr;
    logic         msi_enabled;
    logic         msi_grant;
    logic         msi_request, msi_request8;
    logic [4:0]   msi_vector_num, msi_vector_num8;
    logic [N-1:0] pending_o, pending8;
    logic [N-1:0] overflow_o, overflow8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    msi_irq_ctrl #(.N_SRC(N), .VEC_BASE(0), .HOLDOFF_CYCLES(HC)) u_dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .irq_src        (irq_src),
        .msi_enabled    (msi_enabled),
        .msi_grant      (msi_grant),
        .msi_request    (msi_request),
        .msi_vector_num (msi_vector_num),
        .pending_o      (pending_o),
        .overflow_o     (overflow_o),
        .overflow_clr   (overflow_clr)
    );

    msi_irq_ctrl #(.N_SRC(N), .VEC_BASE(8), .HOLDOFF_CYCLES(HC)) u_dut8 (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .irq_src        (irq_src),
        .msi_enabled    (msi_enabled),
        .msi_grant      (msi_grant),
        .msi_request    (msi_request8),
        .msi_vector_num (msi_vector_num8),
        .pending_o      (pending8),
        .overflow_o     (overflow8),
        .overflow_clr   (overflow_clr)
    );

    // Reference model: outstanding-request flag, pending/overflow sets, next RR start.
    bit [N-1:0] m_prev, m_pend, m_ovf;
    bit         m_busy;
    int         m_cur, m_next, m_hold;
    int         m_vec, m_vec8;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_ovf = '0;
        m_busy = 1'b0; m_cur = 0; m_next = 0; m_hold = 0;
        m_vec = 0; m_vec8 = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] edges, clr;
        bit granted, dropped;
        int w;
        edges   = irq_src & ~m_prev;
        granted = m_busy && msi_grant;
        dropped = m_busy && !msi_grant && !msi_enabled;
        clr     = '0;
        if (granted) clr[m_cur] = 1'b1;
        w = -1;
        if (!m_busy && m_hold == 0 && msi_enabled) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_next + k) % N;
                if (w < 0 && m_pend[j]) w = j;
            end
        end
        m_ovf  = (m_ovf & ~overflow_clr) | (edges & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | edges;
        if (m_hold > 0) m_hold--;
        if (granted) begin
            m_busy = 1'b0;
            m_next = (m_cur + 1) % N;
`ifdef MSI_HOLDOFF_EN
            m_hold = HC;
`endif
        end else if (dropped) begin
            m_busy = 1'b0;
        end else if (w >= 0) begin
            m_busy = 1'b1;
            m_cur  = w;
            m_vec  = w;
            m_vec8 = w + 8;
        end
        m_prev = irq_src;
    endtask

    task automatic check_model(string tag);
        n_tests++;
        if (msi_request !== m_busy || msi_vector_num !== 5'(m_vec) || pending_o !== m_pend ||
            overflow_o !== m_ovf || msi_request8 !== m_busy || msi_vector_num8 !== 5'(m_vec8) ||
            pending8 !== m_pend || overflow8 !== m_ovf) begin
            n_fail++;
            $display("FAIL %s: got req=%0b/%0b vec=%0d/%0d pend=%b ovf=%b, expected req=%0b vec=%0d/%0d pend=%b ovf=%b",
                     tag, msi_request, msi_request8, msi_vector_num, msi_vector_num8, pending_o, overflow_o,
                     m_busy, m_vec, m_vec8, m_pend, m_ovf);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: inputs already driven, model advances at the edge, outputs checked 1ns later.
    task automatic cycle(string tag);
        @(posedge aclk);
        model_step();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic         en;
        logic         g;
        logic [N-1:0] oclr;
        logic         req;
        int           vec;
        int           vec8;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } row_t;

    row_t tbl[$];
    int   lat, gap;

    initial begin
        // irq, en, grant, ovf_clr  ->  req, vec, vec8, pending, overflow
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 0, 0,  0, 4'b0000, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 0, 0,  0, 4'b1011, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 1, 0,  8, 4'b1011, 4'b0000});
        tbl.push_back('{4'b1011, 1, 1, 4'b0000, 0, 0,  8, 4'b1010, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 1, 1,  9, 4'b1010, 4'b0000});
        tbl.push_back('{4'b1011, 1, 1, 4'b0000, 0, 1,  9, 4'b1000, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 1, 3, 11, 4'b1000, 4'b0000});
        tbl.push_back('{4'b1011, 1, 1, 4'b0000, 0, 3, 11, 4'b0000, 4'b0000});
        tbl.push_back('{4'b1010, 1, 0, 4'b0000, 0, 3, 11, 4'b0000, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 0, 3, 11, 4'b0001, 4'b0000});
        tbl.push_back('{4'b1011, 1, 0, 4'b0000, 1, 0,  8, 4'b0001, 4'b0000});
        tbl.push_back('{4'b1011, 1, 1, 4'b0000, 0, 0,  8, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0,  8, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0100, 0, 0, 4'b0000, 0, 0,  8, 4'b0100, 4'b0000});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0,  8, 4'b0100, 4'b0000});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 0,  8, 4'b0100, 4'b0000});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 1, 2, 10, 4'b0100, 4'b0000});
        tbl.push_back('{4'b0000, 1, 1, 4'b0000, 0, 2, 10, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0010, 1, 0, 4'b0000, 0, 2, 10, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 1, 1,  9, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0010, 1, 0, 4'b0000, 1, 1,  9, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 1, 1,  9, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 0, 0, 4'b0000, 0, 1,  9, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 0, 0, 4'b0010, 0, 1,  9, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0010, 0, 0, 4'b0010, 0, 1,  9, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 1, 0, 4'b0010, 1, 1,  9, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0000, 1, 1, 4'b0000, 0, 1,  9, 4'b0000, 4'b0000});
        tbl.push_back('{4'b1000, 1, 0, 4'b0000, 0, 1,  9, 4'b1000, 4'b0000});
        tbl.push_back('{4'b0000, 1, 0, 4'b0000, 1, 3, 11, 4'b1000, 4'b0000});
        tbl.push_back('{4'b1000, 1, 1, 4'b0000, 0, 3, 11, 4'b1000, 4'b0000});
        tbl.push_back('{4'b1000, 1, 0, 4'b0000, 1, 3, 11, 4'b1000, 4'b0000});
        tbl.push_back('{4'b1000, 1, 1, 4'b0000, 0, 3, 11, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0000, 1, 1, 4'b0000, 0, 3, 11, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0001, 1, 1, 4'b0000, 0, 3, 11, 4'b0001, 4'b0000});
        tbl.push_back('{4'b0001, 1, 1, 4'b0000, 1, 0,  8, 4'b0001, 4'b0000});
        tbl.push_back('{4'b0001, 1, 0, 4'b0000, 1, 0,  8, 4'b0001, 4'b0000});
        tbl.push_back('{4'b0001, 1, 1, 4'b0000, 0, 0,  8, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0011, 1, 0, 4'b0000, 0, 0,  8, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0011, 1, 0, 4'b0000, 1, 1,  9, 4'b0010, 4'b0000});
        tbl.push_back('{4'b0011, 0, 1, 4'b0000, 0, 1,  9, 4'b0000, 4'b0000});

        aresetn = 1'b0; irq_src = '0; overflow_clr = '0; msi_enabled = 1'b0; msi_grant = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check_val("reset_req", int'(msi_request), 0);
        check_val("reset_vec", int'(msi_vector_num), 0);
        check_val("reset_pend", int'(pending_o), 0);
        check_val("reset_ovf", int'(overflow_o), 0);
        aresetn = 1'b1;

`ifndef MSI_HOLDOFF_EN
        for (int i = 0; i < tbl.size(); i++) begin
            irq_src = tbl[i].irq; msi_enabled = tbl[i].en;
            msi_grant = tbl[i].g; overflow_clr = tbl[i].oclr;
            cycle($sformatf("model_row%0d", i));
            n_tests++;
            if (msi_request !== tbl[i].req || msi_vector_num !== 5'(tbl[i].vec) ||
                msi_vector_num8 !== 5'(tbl[i].vec8) || pending_o !== tbl[i].pend ||
                overflow_o !== tbl[i].ovf) begin
                n_fail++;
                $display("FAIL row%0d: got req=%0b vec=%0d vec8=%0d pend=%b ovf=%b, expected req=%0b vec=%0d vec8=%0d pend=%b ovf=%b",
                         i, msi_request, msi_vector_num, msi_vector_num8, pending_o, overflow_o,
                         tbl[i].req, tbl[i].vec, tbl[i].vec8, tbl[i].pend, tbl[i].ovf);
            end
        end
`endif

        // Async reset while a request is outstanding.
        msi_grant = 1'b0; overflow_clr = '0; msi_enabled = 1'b1; irq_src = 4'b0000;
        cycle("pre_rst_clear");
        irq_src = 4'b0100;
        cycle("pre_rst_edge");
        cycle("pre_rst_req");
        check_val("rst_mid_req_before", int'(msi_request), 1);
        #2 aresetn = 1'b0;
        #1;
        check_val("rst_mid_req_drop", int'(msi_request), 0);
        check_val("rst_mid_req_pend", int'(pending_o), 0);
        check_val("rst_mid_req_vec8", int'(msi_vector_num8), 0);
        model_reset();
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Request latency from an edge, then spacing to the next request after a grant.
        irq_src = 4'b0011; msi_enabled = 1'b1; msi_grant = 1'b0;
        lat = 0;
        while (lat < 10) begin
            cycle("lat_wait");
            lat++;
            if (msi_request) break;
        end
        check_val("first_req_latency", lat, 2);
        msi_grant = 1'b1;
        cycle("gap_grant");
        msi_grant = 1'b0;
        gap = 1;
        while (gap < 200) begin
            cycle("gap_wait");
            gap++;
            if (msi_request) break;
        end
        check_val("grant_to_next_req", gap, EXP_GAP);
        check_val("second_vec", int'(msi_vector_num), 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
            end
            msi_enabled  = ($urandom_range(0, 15) != 0);
            msi_grant    = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            cycle($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
